// File: rtl/uart_lite_pkg.sv
// uart_lite_pkg: shared constants for the uart_lite peripheral.
//   - byte offsets of the register map
//   - bit positions inside INTR_*, CTRL and STATUS
//   - TX / RX FSM state encodings and the parity helper
package uart_lite_pkg;

  localparam logic [5:0] REG_INTR_STATE  = 6'h00;
  localparam logic [5:0] REG_INTR_ENABLE = 6'h04;
  localparam logic [5:0] REG_CTRL        = 6'h10;
  localparam logic [5:0] REG_STATUS      = 6'h14;
  localparam logic [5:0] REG_RDATA       = 6'h18;
  localparam logic [5:0] REG_WDATA       = 6'h1C;

  localparam int INTR_TX_EMPTY   = 0;
  localparam int INTR_RX_VALID   = 1;
  localparam int INTR_FRAME_ERR  = 2;
  localparam int INTR_PARITY_ERR = 3;

  localparam int CTRL_TX       = 0;
  localparam int CTRL_RX       = 1;
  localparam int CTRL_PAR_EN   = 6;
  localparam int CTRL_PAR_ODD  = 7;
  localparam int CTRL_NCO_LSB  = 16;

  localparam int ST_TXFULL  = 0;
  localparam int ST_RXFULL  = 1;
  localparam int ST_TXEMPTY = 2;
  localparam int ST_TXIDLE  = 3;
  localparam int ST_RXIDLE  = 4;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  function automatic logic par_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_lite_fifo.sv
// uart_lite_fifo: synchronous show-ahead FIFO for the TX path.
//   i_clk/i_rst   clock, async active-high reset
//   i_push/i_wdata write side; a push while full is dropped
//   i_pop         read side; o_rdata is the current head
//   o_full/o_empty/o_cnt occupancy
module uart_lite_fifo #(
  parameter int Depth = 8,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_cnt
);
  localparam int AW = $clog2(Depth);

  logic [W-1:0] r_mem [Depth];
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_push, w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_cnt   = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (o_cnt == (AW+1)'(Depth));
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_lite.sv
// uart_lite: register-mapped UART (8N1, optional parity) on a TL-UL-lite port.
//   clk_i/rst_i            clock, async active-high reset
//   bus_req_i/bus_gnt_o    request handshake (gnt = !rvalid | rready)
//   bus_we_i/addr/wdata    request payload
//   bus_rvalid_o/rdata/err response, held until bus_rready_i
//   rx_i / tx_o            serial pads, idle high; tx_en_o mirrors CTRL.TX
//   intr_*_o               INTR_STATE & INTR_ENABLE
// Build option: define UART_LITE_PARITY_EN to enable parity generation/check.
module uart_lite
  import uart_lite_pkg::*;
#(
  parameter int TxDepth = 8,
  parameter int NcoW    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  output logic        bus_gnt_o,
  input  logic        bus_we_i,
  input  logic [5:0]  bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_rvalid_o,
  output logic [31:0] bus_rdata_o,
  output logic        bus_err_o,
  input  logic        bus_rready_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        tx_en_o,
  output logic        intr_tx_empty_o,
  output logic        intr_rx_valid_o,
  output logic        intr_rx_frame_err_o,
  output logic        intr_rx_parity_err_o
);
  localparam int CntW = $clog2(TxDepth) + 1;

  // ---------------- registers / bus ----------------
  logic            r_ctrl_tx, r_ctrl_rx;
  logic [NcoW-1:0] r_nco, r_acc;
  logic [3:0]      r_intr_state, r_intr_en;
  logic            r_rvalid, r_err;
  logic [31:0]     r_rdata;
  logic            r_rxfull;
  logic [7:0]      r_rx_byte;
  logic            w_par_en, w_par_odd;
  logic            w_accept, w_wr, w_mapped;
  logic [3:0]      w_idx, w_w1c, w_intr_set, w_intr_mask;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_unused  = ^{bus_addr_i[1:0], bus_wdata_i[15:2]};
  assign bus_gnt_o = ~r_rvalid | bus_rready_i;
  assign w_accept  = bus_req_i & bus_gnt_o;
  assign w_wr      = w_accept & bus_we_i;
  assign w_idx     = bus_addr_i[5:2];

`ifdef UART_LITE_PARITY_EN
  logic r_par_en, r_par_odd;
  assign w_par_en    = r_par_en;
  assign w_par_odd   = r_par_odd;
  assign w_intr_mask = 4'hF;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
    end else if (w_wr && w_idx == REG_CTRL[5:2]) begin
      r_par_en  <= bus_wdata_i[CTRL_PAR_EN];
      r_par_odd <= bus_wdata_i[CTRL_PAR_ODD];
    end
  end
`else
  assign w_par_en    = 1'b0;
  assign w_par_odd   = 1'b0;
  assign w_intr_mask = 4'h7;
`endif

  // ---------------- TX FIFO / FSM signals ----------------
  tx_state_e     r_tx_state;
  rx_state_e     r_rx_state;
  logic          w_fifo_full, w_fifo_empty, w_push, w_tx_pop;
  logic [7:0]    w_fifo_rdata;
  logic [CntW-1:0] w_fifo_cnt;

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    case (w_idx)
      REG_INTR_STATE[5:2]:  w_rdata[3:0] = r_intr_state;
      REG_INTR_ENABLE[5:2]: w_rdata[3:0] = r_intr_en;
      REG_CTRL[5:2]:        w_rdata = {16'(r_nco), 8'h00, w_par_odd, w_par_en,
                                       4'h0, r_ctrl_rx, r_ctrl_tx};
      REG_STATUS[5:2]:      w_rdata[4:0] = {r_rx_state == RX_IDLE, r_tx_state == TX_IDLE,
                                            w_fifo_empty, r_rxfull, w_fifo_full};
      REG_RDATA[5:2]:       w_rdata[7:0] = r_rxfull ? r_rx_byte : 8'h00;
      REG_WDATA[5:2]:       w_rdata = '0;
      default:              w_mapped = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_rvalid <= 1'b1;
      r_rdata  <= (bus_we_i || !w_mapped) ? 32'h0 : w_rdata;
      r_err    <= ~w_mapped;
    end else if (bus_rready_i) begin
      r_rvalid <= 1'b0;
    end
  end

  assign bus_rvalid_o = r_rvalid;
  assign bus_rdata_o  = r_rdata;
  assign bus_err_o    = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ctrl_tx <= 1'b0;
      r_ctrl_rx <= 1'b0;
      r_nco     <= '0;
      r_intr_en <= '0;
    end else begin
      if (w_wr && w_idx == REG_CTRL[5:2]) begin
        r_ctrl_tx <= bus_wdata_i[CTRL_TX];
        r_ctrl_rx <= bus_wdata_i[CTRL_RX];
        r_nco     <= bus_wdata_i[CTRL_NCO_LSB +: NcoW];
      end
      if (w_wr && w_idx == REG_INTR_ENABLE[5:2]) r_intr_en <= bus_wdata_i[3:0];
    end
  end

  // Hardware set is OR'ed in after the W1C so a coincident set wins.
  assign w_w1c = (w_wr && w_idx == REG_INTR_STATE[5:2]) ? bus_wdata_i[3:0] : 4'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_intr_state <= '0;
    else       r_intr_state <= ((r_intr_state & ~w_w1c) | w_intr_set) & w_intr_mask;
  end

  assign intr_tx_empty_o      = r_intr_state[INTR_TX_EMPTY]  & r_intr_en[INTR_TX_EMPTY];
  assign intr_rx_valid_o      = r_intr_state[INTR_RX_VALID]  & r_intr_en[INTR_RX_VALID];
  assign intr_rx_frame_err_o  = r_intr_state[INTR_FRAME_ERR] & r_intr_en[INTR_FRAME_ERR];
`ifdef UART_LITE_PARITY_EN
  assign intr_rx_parity_err_o = r_intr_state[INTR_PARITY_ERR] & r_intr_en[INTR_PARITY_ERR];
`else
  assign intr_rx_parity_err_o = 1'b0;
`endif

  // ---------------- baud NCO ----------------
  logic            w_nco_en, w_tick16, w_bit_tick;
  logic [NcoW:0]   w_sum;
  logic [3:0]      r_div;

  // Keep ticking while a frame is in flight so clearing CTRL.TX lets it finish.
  assign w_nco_en   = r_ctrl_tx | r_ctrl_rx | (r_tx_state != TX_IDLE);
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_nco};
  assign w_tick16   = w_nco_en & w_sum[NcoW];
  assign w_bit_tick = w_tick16 & (r_div == 4'hF);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_div <= '0;
    end else if (w_nco_en) begin
      r_acc <= w_sum[NcoW-1:0];
      if (w_tick16) r_div <= r_div + 4'd1;
    end
  end

  // ---------------- TX ----------------
  logic       r_tx, r_tx_par;
  logic [7:0] r_tx_sh;
  logic [2:0] r_tx_bits;

  assign w_push   = w_wr && w_idx == REG_WDATA[5:2];
  assign w_tx_pop = (r_tx_state == TX_IDLE) & w_bit_tick & r_ctrl_tx & ~w_fifo_empty;

  uart_lite_fifo #(.Depth(TxDepth), .W(8)) u_txfifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_wdata (bus_wdata_i[7:0]),
    .i_pop   (w_tx_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_cnt   (w_fifo_cnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_sh    <= '0;
      r_tx_bits  <= '0;
      r_tx_par   <= 1'b0;
    end else if (w_bit_tick) begin
      case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          r_tx_state <= TX_START;
          r_tx       <= 1'b0;
          r_tx_sh    <= w_fifo_rdata;
          r_tx_par   <= par_bit(w_fifo_rdata, w_par_odd);
        end
        TX_START: begin
          r_tx_state <= TX_DATA;
          r_tx       <= r_tx_sh[0];
          r_tx_sh    <= r_tx_sh >> 1;
          r_tx_bits  <= '0;
        end
        TX_DATA: if (r_tx_bits == 3'd7) begin
          r_tx_state <= w_par_en ? TX_PARITY : TX_STOP;
          r_tx       <= w_par_en ? r_tx_par : 1'b1;
        end else begin
          r_tx      <= r_tx_sh[0];
          r_tx_sh   <= r_tx_sh >> 1;
          r_tx_bits <= r_tx_bits + 3'd1;
        end
        TX_PARITY: begin
          r_tx_state <= TX_STOP;
          r_tx       <= 1'b1;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx_o    = r_tx;
  assign tx_en_o = r_ctrl_tx;

  // ---------------- RX ----------------
  logic [1:0] r_sync;
  logic [3:0] r_rx_cnt;
  logic [2:0] r_rx_bits;
  logic [7:0] r_rx_sh;
  logic       r_rx_done, r_rx_ferr, r_rx_perr, w_rx;

  // Synchronizer resets to the idle-high line level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx_i};
  end
  assign w_rx = r_sync[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_sh    <= '0;
      r_rx_done  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_perr  <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      r_rx_ferr <= 1'b0;
      r_rx_perr <= 1'b0;
      if (!r_ctrl_rx) begin
        r_rx_state <= RX_IDLE;
      end else if (w_tick16) begin
        case (r_rx_state)
          RX_IDLE: if (!w_rx) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
          // Re-check at the start-bit midpoint to reject glitches.
          RX_START: if (r_rx_cnt == 4'd7) begin
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
          end else begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
          end
          RX_DATA: begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
            if (r_rx_cnt == 4'hF) begin
              r_rx_sh   <= {w_rx, r_rx_sh[7:1]};
              r_rx_bits <= r_rx_bits + 3'd1;
              if (r_rx_bits == 3'd7) r_rx_state <= w_par_en ? RX_PARITY : RX_STOP;
            end
          end
          RX_PARITY: begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
            if (r_rx_cnt == 4'hF) begin
              r_rx_perr  <= (w_rx != par_bit(r_rx_sh, w_par_odd));
              r_rx_state <= RX_STOP;
            end
          end
          RX_STOP: begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
            if (r_rx_cnt == 4'hF) begin
              r_rx_done  <= w_rx;
              r_rx_ferr  <= ~w_rx;
              r_rx_state <= RX_IDLE;
            end
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // A newly delivered byte beats a coincident RDATA read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rxfull  <= 1'b0;
      r_rx_byte <= '0;
    end else if (r_rx_done) begin
      r_rxfull  <= 1'b1;
      r_rx_byte <= r_rx_sh;
    end else if (w_accept && !bus_we_i && w_idx == REG_RDATA[5:2]) begin
      r_rxfull  <= 1'b0;
    end
  end

  assign w_intr_set = {r_rx_perr, r_rx_ferr, r_rx_done,
                       w_tx_pop & (w_fifo_cnt == CntW'(1)) & ~w_push};

endmodule

// File: tb/tb_uart_lite.sv
module tb_uart_lite;
`ifdef UART_LITE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, gnt, we, rvalid, err, rready, rx, tx, tx_en;
  logic [5:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  irq;
  int          errs = 0, checks = 0;

  always #5 clk = ~clk;

  uart_lite dut (
    .clk_i(clk), .rst_i(rst),
    .bus_req_i(req), .bus_gnt_o(gnt), .bus_we_i(we), .bus_addr_i(addr),
    .bus_wdata_i(wdata), .bus_rvalid_o(rvalid), .bus_rdata_o(rdata),
    .bus_err_o(err), .bus_rready_i(rready),
    .rx_i(rx), .tx_o(tx), .tx_en_o(tx_en),
    .intr_tx_empty_o(irq[0]), .intr_rx_valid_o(irq[1]),
    .intr_rx_frame_err_o(irq[2]), .intr_rx_parity_err_o(irq[3])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus transaction with rready high; response expected the next cycle.
  task automatic xfer(input logic w, input logic [5:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    chk("rsp_valid", rvalid, 1'b1);
    rd = rdata;
    er = err;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] rd; logic er;
    xfer(1'b1, a, d, rd, er);
  endtask

  task automatic rd_chk(input logic [5:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd; logic er;
    xfer(1'b0, a, 32'h0, rd, er);
    chk(tag, rd, exp);
  endtask

  // Wait (bounded) for a start bit on tx, then sample each bit mid-cell.
  task automatic get_frame(input bit par_on, output logic [7:0] d, output bit ok);
    int n = 0;
    ok = 1'b0; d = 8'h00;
    @(negedge clk);
    while (tx !== 1'b0 && n < 600) begin @(negedge clk); n++; end
    if (tx !== 1'b0) return;
    ok = 1'b1;
    repeat (8) @(negedge clk);
    chk("tx_start", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      d[i] = tx;
    end
    if (par_on) begin
      repeat (16) @(negedge clk);
      chk("tx_parity", tx, ^d);
    end
    repeat (16) @(negedge clk);
    chk("tx_stop", tx, 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    @(negedge clk); rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    logic [31:0] d; logic e; logic [7:0] b; bit ok;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; rready = 1'b1; rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_txen", tx_en, 1'b0);
    chk("rst_gnt", gnt, 1'b1);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_irq", irq, 4'h0);
    rst = 1'b0;
    rd_chk(6'h14, 32'h1C, "status_rst");

    // bus corner cases
    xfer(1'b0, 6'h3C, 32'h0, d, e);
    chk("unmapped_rd_err", e, 1'b1);
    chk("unmapped_rd_data", d, 32'h0);
    xfer(1'b1, 6'h3C, 32'hFFFF_FFFF, d, e);
    chk("unmapped_wr_err", e, 1'b1);
    xfer(1'b1, 6'h14, 32'hFFFF_FFFF, d, e);
    chk("ro_wr_err", e, 1'b0);
    rd_chk(6'h14, 32'h1C, "status_after_ro_wr");

    // response back-pressure
    rready = 1'b0;
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 6'h14;
    @(negedge clk); req = 1'b0;
    chk("bp_rvalid0", rvalid, 1'b1);
    chk("bp_gnt0", gnt, 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_rvalid_held", rvalid, 1'b1);
    chk("bp_gnt_held", gnt, 1'b0);
    chk("bp_rdata", rdata, 32'h1C);
    rready = 1'b1;
    @(negedge clk);
    chk("bp_release_rvalid", rvalid, 1'b0);
    chk("bp_release_gnt", gnt, 1'b1);

    // TX with even parity (parity only present in the parity build)
    wr(6'h1C, 32'hAF);
    wr(6'h1C, 32'hAA);
    wr(6'h10, 32'hFFFF_0041);
    rd_chk(6'h10, PAR ? 32'hFFFF_0041 : 32'hFFFF_0001, "ctrl_readback");
    chk("tx_en", tx_en, 1'b1);
    get_frame(PAR, b, ok);
    chk("f1_seen", ok, 1'b1);
    chk("f1_data", b, 8'hAF);
    rd_chk(6'h00, 32'h0, "intr_after_pop1");
    get_frame(PAR, b, ok);
    chk("f2_seen", ok, 1'b1);
    chk("f2_data", b, 8'hAA);
    rd_chk(6'h00, 32'h1, "intr_after_pop2");
    wr(6'h00, 32'h1);
    rd_chk(6'h00, 32'h0, "intr_w1c");
    repeat (40) @(negedge clk);

    // RX good frame
    wr(6'h10, 32'hFFFF_0002);
    send_rx(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    rd_chk(6'h14, 32'h1E, "rx_status_full");
    rd_chk(6'h00, 32'h2, "rx_valid_intr");
    rd_chk(6'h18, 32'h5A, "rx_rdata");
    rd_chk(6'h14, 32'h1C, "rx_status_after_read");
    rd_chk(6'h18, 32'h0, "rx_rdata_empty");
    wr(6'h00, 32'hF);

    // RX frame with stop bit 0
    send_rx(8'h5A, 1'b0);
    repeat (30) @(negedge clk);
    rd_chk(6'h00, 32'h4, "frame_err_intr");
    rd_chk(6'h14, 32'h1C, "frame_err_status");
    wr(6'h04, 32'h4);
    chk("irq_frame_pin", irq[2], 1'b1);
    chk("irq_rxv_pin", irq[1], 1'b0);
    wr(6'h04, 32'h0);
    wr(6'h00, 32'hF);

    // FIFO overflow, then drain
    wr(6'h10, 32'hFFFF_0000);
    for (int i = 0; i < 9; i++) wr(6'h1C, 32'(i + 1));
    rd_chk(6'h14, 32'h19, "fifo_full_status");
    wr(6'h10, 32'hFFFF_0001);
    for (int i = 0; i < 8; i++) begin
      get_frame(1'b0, b, ok);
      chk("drain_seen", ok, 1'b1);
      chk("drain_data", b, 8'(i + 1));
    end
    get_frame(1'b0, b, ok);
    chk("no_ninth_frame", ok, 1'b0);
    rd_chk(6'h14, 32'h1C, "drain_status");
    rd_chk(6'h00, 32'h1, "drain_tx_empty");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
